calendar_date_counter: RTL

Parametrised day/month/year counter for the century clock. It replaces the standalone day counter with one block that owns the whole date. Day-of-month limits are computed internally, including leap years. Each field supports auto-advance, manual per-field edit and parallel load, and the block clamps the day whenever the month limit shrinks. It sits below the time-of-day counters: their midnight carry drives `tick_day`, and the setting UI drives the manual and load inputs.

---
 rtl/date_pkg.sv | 39 +++
 rtl/days_in_month.sv | 31 +++
 rtl/calendar_date_counter.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/date_pkg.sv
// ============================================================================
// Module   : date_pkg
// Purpose  : Shared constants for the calendar date counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package date_pkg;

    localparam int MONTH_W = 4;
    localparam int DAY_W   = 5;

    localparam logic [1:0] SEL_DAY   = 2'd0;
    localparam logic [1:0] SEL_MONTH = 2'd1;
    localparam logic [1:0] SEL_YEAR  = 2'd2;
    localparam logic [1:0] SEL_NONE  = 2'd3;

    localparam logic [MONTH_W-1:0] JAN = 4'd1;
    localparam logic [MONTH_W-1:0] FEB = 4'd2;
    localparam logic [MONTH_W-1:0] MAR = 4'd3;
    localparam logic [MONTH_W-1:0] APR = 4'd4;
    localparam logic [MONTH_W-1:0] MAY = 4'd5;
    localparam logic [MONTH_W-1:0] JUN = 4'd6;
    localparam logic [MONTH_W-1:0] JUL = 4'd7;
    localparam logic [MONTH_W-1:0] AUG = 4'd8;
    localparam logic [MONTH_W-1:0] SEP = 4'd9;
    localparam logic [MONTH_W-1:0] OCT = 4'd10;
    localparam logic [MONTH_W-1:0] NOV = 4'd11;
    localparam logic [MONTH_W-1:0] DEC = 4'd12;

    // Non-leap lengths; February is patched to 29 in leap years.
    localparam logic [DAY_W-1:0] BASE_DIM [12] = '{
        5'd31, 5'd28, 5'd31, 5'd30, 5'd31, 5'd30,
        5'd31, 5'd31, 5'd30, 5'd31, 5'd30, 5'd31
    };

endpackage

`default_nettype wire

// File: rtl/days_in_month.sv
// ============================================================================
// Module   : days_in_month
// Purpose  : Combinational month length and Gregorian leap-year flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module days_in_month
    import date_pkg::*;
(
    input  logic [MONTH_W-1:0] month,
    input  logic [15:0]        full_year,
    output logic [DAY_W-1:0]   dim,
    output logic               leap
);

    always_comb begin
        leap = (full_year[1:0] == 2'b00) &&
               (((full_year % 16'd100) != 16'd0) || ((full_year % 16'd400) == 16'd0));
        dim  = 5'd31;
        if (month >= JAN && month <= DEC) begin
            dim = BASE_DIM[month - 4'd1];
            if (month == FEB && leap) begin
                dim = 5'd29;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/calendar_date_counter.sv
// ============================================================================
// Module   : calendar_date_counter
// Purpose  : Day/month/year register with auto-advance, manual edit, load and clamp.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module calendar_date_counter
    import date_pkg::*;
#(
    parameter int YEAR_W       = 7,
    parameter int YEAR_MAX     = 99,
    parameter int CENTURY_BASE = 2000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                tick_day,
    input  logic [1:0]          sel,
    input  logic                inc_manual,
    input  logic                dec_manual,
    input  logic                load,
    input  logic [4:0]          load_day,
    input  logic [3:0]          load_month,
    input  logic [YEAR_W-1:0]   load_year,
    output logic [4:0]          day,
    output logic [3:0]          month,
    output logic [YEAR_W-1:0]   year,
    output logic [4:0]          dim,
    output logic                leap,
    output logic                carry_month,
    output logic                carry_year,
    output logic                century_wrap
);

    localparam logic [YEAR_W-1:0] YEAR_LAST = YEAR_W'(YEAR_MAX);
    localparam logic [YEAR_W-1:0] YEAR_ONE  = YEAR_W'(1);
    localparam logic [15:0]       BASE16    = 16'(CENTURY_BASE);

    logic [DAY_W-1:0]   r_day;
    logic [MONTH_W-1:0] r_month;
    logic [YEAR_W-1:0]  r_year;
    logic               r_carry_month;
    logic               r_carry_year;
    logic               r_century_wrap;
    logic               r_tick_pending;

    logic               w_manual;
    logic               w_do_tick;
    logic               w_next_pending;
    logic [DAY_W-1:0]   w_cur_dim;
    logic               w_cur_leap;
    logic [DAY_W-1:0]   w_raw_day;
    logic [DAY_W-1:0]   w_next_day;
    logic [MONTH_W-1:0] w_next_month;
    logic [YEAR_W-1:0]  w_next_year;
    logic [DAY_W-1:0]   w_next_dim;
    logic               w_next_leap;
    logic               w_cm;
    logic               w_cy;
    logic               w_cw;

    days_in_month u_dim_cur (
        .month     (r_month),
        .full_year (BASE16 + 16'(r_year)),
        .dim       (w_cur_dim),
        .leap      (w_cur_leap)
    );

    // Second instance evaluates the candidate month/year so the day can be clamped in the same update.
    days_in_month u_dim_next (
        .month     (w_next_month),
        .full_year (BASE16 + 16'(w_next_year)),
        .dim       (w_next_dim),
        .leap      (w_next_leap)
    );

    assign w_manual       = inc_manual | dec_manual;
    assign w_do_tick      = !load && !w_manual && (tick_day || r_tick_pending);
    assign w_next_pending = !load && w_manual && (tick_day || r_tick_pending);

    always_comb begin
        w_raw_day    = r_day;
        w_next_month = r_month;
        w_next_year  = r_year;
        w_cm         = 1'b0;
        w_cy         = 1'b0;
        w_cw         = 1'b0;
        if (load) begin
            w_raw_day    = (load_day == 5'd0) ? 5'd1 : load_day;
            w_next_month = (load_month == 4'd0) ? JAN : ((load_month > DEC) ? DEC : load_month);
            w_next_year  = (load_year > YEAR_LAST) ? YEAR_LAST : load_year;
        end else if (dec_manual) begin
            case (sel)
                SEL_DAY:   w_raw_day    = (r_day <= 5'd1) ? w_cur_dim : r_day - 5'd1;
                SEL_MONTH: w_next_month = (r_month <= JAN) ? DEC : r_month - 4'd1;
                SEL_YEAR:  w_next_year  = (r_year == '0) ? YEAR_LAST : r_year - YEAR_ONE;
                default:   ;
            endcase
        end else if (inc_manual) begin
            case (sel)
                SEL_DAY:   w_raw_day    = (r_day >= w_cur_dim) ? 5'd1 : r_day + 5'd1;
                SEL_MONTH: w_next_month = (r_month >= DEC) ? JAN : r_month + 4'd1;
                SEL_YEAR:  w_next_year  = (r_year >= YEAR_LAST) ? '0 : r_year + YEAR_ONE;
                default:   ;
            endcase
        end else if (w_do_tick) begin
            if (r_day >= w_cur_dim) begin
                w_raw_day = 5'd1;
                w_cm      = 1'b1;
                if (r_month >= DEC) begin
                    w_next_month = JAN;
                    w_cy         = 1'b1;
                    if (r_year >= YEAR_LAST) begin
                        w_next_year = '0;
                        w_cw        = 1'b1;
                    end else begin
                        w_next_year = r_year + YEAR_ONE;
                    end
                end else begin
                    w_next_month = r_month + 4'd1;
                end
            end else begin
                w_raw_day = r_day + 5'd1;
            end
        end
        w_next_day = (w_raw_day > w_next_dim) ? w_next_dim : w_raw_day;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_day          <= 5'd1;
            r_month        <= JAN;
            r_year         <= '0;
            r_carry_month  <= 1'b0;
            r_carry_year   <= 1'b0;
            r_century_wrap <= 1'b0;
            r_tick_pending <= 1'b0;
        end else begin
            r_day          <= w_next_day;
            r_month        <= w_next_month;
            r_year         <= w_next_year;
            r_carry_month  <= w_cm;
            r_carry_year   <= w_cy;
            r_century_wrap <= w_cw;
            r_tick_pending <= w_next_pending;
        end
    end

    assign day          = r_day;
    assign month        = r_month;
    assign year         = r_year;
    assign dim          = w_cur_dim;
    assign leap         = w_cur_leap;
    assign carry_month  = r_carry_month;
    assign carry_year   = r_carry_year;
    assign century_wrap = r_century_wrap;

    logic w_unused;
    assign w_unused = w_next_leap;

endmodule

`default_nettype wire
